// File: rtl/pieo_sched_pkg.sv
// Shared types and default widths for the PIEO enqueue path.
// No logic; constants and the controller state encoding only.
// Backpressure: n/a.
package pieo_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_REQ   = 2'd2
  } enq_state_t;

  localparam int DEF_LEN_WIDTH   = 16;
  localparam int DEF_RANK_WIDTH  = 32;
  localparam int DEF_SHIFT_WIDTH = 3;

  // Saturation value for virtual finish times at the default rank width.
  localparam logic [DEF_RANK_WIDTH-1:0] RANK_MAX = {DEF_RANK_WIDTH{1'b1}};

endpackage

// File: rtl/vft_calc.sv
// Start-time fair queueing step: scaled length, start = max(now, last), saturating finish.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit the result.
module vft_calc
  import pieo_sched_pkg::*;
#(
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int RANK_WIDTH  = DEF_RANK_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic [LEN_WIDTH-1:0]   head_len,
  input  logic [SHIFT_WIDTH-1:0] shift,
  input  logic [RANK_WIDTH-1:0]  now,
  input  logic [RANK_WIDTH-1:0]  last_finish,
  output logic [RANK_WIDTH-1:0]  start_vt,
  output logic [RANK_WIDTH-1:0]  finish_vt
);

  logic [RANK_WIDTH-1:0] scaled_len;
  logic [RANK_WIDTH:0]   sum;

  // Heavier flows (larger shift) consume less virtual time per byte.
  assign scaled_len = RANK_WIDTH'(head_len >> shift);

  // A flow that has been idle restarts at the system virtual time.
  assign start_vt = (now > last_finish) ? now : last_finish;

  // One extra bit catches the wrap so the finish time pins at all-ones.
  assign sum       = {1'b0, start_vt} + {1'b0, scaled_len};
  assign finish_vt = sum[RANK_WIDTH] ? {RANK_WIDTH{1'b1}} : sum[RANK_WIDTH-1:0];

endmodule

// File: rtl/pieo_enq_ctrl.sv
// Claims an offered FIFO, reads its head length, computes an SFQ rank, enqueues {fifo, rank} into the PIEO.
// Latency: claim at t, request valid from t+2; next claim possible the cycle after the accept.
// Backpressure: request held stable until pieo_enq_ready; no new offer examined until back in IDLE.
module pieo_enq_ctrl
  import pieo_sched_pkg::*;
#(
  parameter int NUM_FIFO    = 4,
  parameter int SEL_WIDTH   = $clog2(NUM_FIFO),
  parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
  parameter int RANK_WIDTH  = DEF_RANK_WIDTH,
  parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            fifo_to_enqueue_valid,
  input  logic [SEL_WIDTH-1:0]            fifo_to_enqueue,
  output logic                            pieo_enq_trigger,
  output logic                            head_len_rd_en,
  output logic [SEL_WIDTH-1:0]            head_len_rd_addr,
  input  logic [LEN_WIDTH-1:0]            head_len_rd_data,
  input  logic [NUM_FIFO*SHIFT_WIDTH-1:0] weight_shift,
  input  logic [RANK_WIDTH-1:0]           now,
  output logic                            pieo_enq_valid,
  input  logic                            pieo_enq_ready,
  output logic [SEL_WIDTH-1:0]            pieo_enq_fifo,
  output logic [RANK_WIDTH-1:0]           pieo_enq_rank,
  output logic                            busy
);

  enq_state_t             state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q;
  logic [RANK_WIDTH-1:0]  last_finish [NUM_FIFO];
  logic [SHIFT_WIDTH-1:0] sel_shift;
  logic [RANK_WIDTH-1:0]  start_vt;
  logic [RANK_WIDTH-1:0]  finish_vt;
  logic                   claim;
  logic                   in_fetch;
  logic                   accept;

  assign sel_shift = weight_shift[int'(sel_q)*SHIFT_WIDTH +: SHIFT_WIDTH];
  assign claim     = (state_q == ST_IDLE) && fifo_to_enqueue_valid;
  assign in_fetch  = (state_q == ST_FETCH);
  assign accept    = (state_q == ST_REQ) && pieo_enq_ready;
  assign busy      = (state_q != ST_IDLE);

  vft_calc #(
    .LEN_WIDTH   (LEN_WIDTH),
    .RANK_WIDTH  (RANK_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_vft_calc (
    .head_len    (head_len_rd_data),
    .shift       (sel_shift),
    .now         (now),
    .last_finish (last_finish[sel_q]),
    .start_vt    (start_vt),
    .finish_vt   (finish_vt)
  );

  // Next state plus the same-cycle claim and head-length read strobes.
  always_comb begin
    state_d          = state_q;
    pieo_enq_trigger = 1'b0;
    head_len_rd_en   = 1'b0;
    head_len_rd_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (fifo_to_enqueue_valid) begin
          pieo_enq_trigger = 1'b1;
          head_len_rd_en   = 1'b1;
          head_len_rd_addr = fifo_to_enqueue;
          state_d          = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_REQ;
      ST_REQ: begin
        if (pieo_enq_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Selected index and the committed PIEO request; request stays put until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q          <= '0;
      pieo_enq_valid <= 1'b0;
      pieo_enq_fifo  <= '0;
      pieo_enq_rank  <= '0;
    end else begin
      if (claim) sel_q <= fifo_to_enqueue;
      if (in_fetch) begin
        pieo_enq_valid <= 1'b1;
        pieo_enq_fifo  <= sel_q;
        pieo_enq_rank  <= start_vt;
      end else if (accept) begin
        pieo_enq_valid <= 1'b0;
      end
    end
  end

  // Per-FIFO virtual finish times; only the entry being enqueued advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FIFO; i++) last_finish[i] <= '0;
    end else if (in_fetch) begin
      last_finish[sel_q] <= finish_vt;
    end
  end

endmodule

// File: tb/tb_pieo_enq_ctrl.sv
module tb_pieo_enq_ctrl;

  localparam int NF = 4;
  localparam int SW = 2;
  localparam int LW = 16;
  localparam int RW = 32;
  localparam int HW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fifo_to_enqueue_valid;
  logic [SW-1:0]   fifo_to_enqueue;
  logic            pieo_enq_trigger;
  logic            head_len_rd_en;
  logic [SW-1:0]   head_len_rd_addr;
  logic [LW-1:0]   head_len_rd_data;
  logic [NF*HW-1:0] weight_shift;
  logic [RW-1:0]   now;
  logic            pieo_enq_valid;
  logic            pieo_enq_ready;
  logic [SW-1:0]   pieo_enq_fifo;
  logic [RW-1:0]   pieo_enq_rank;
  logic            busy;

  pieo_enq_ctrl #(.NUM_FIFO(NF)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .fifo_to_enqueue_valid (fifo_to_enqueue_valid),
    .fifo_to_enqueue       (fifo_to_enqueue),
    .pieo_enq_trigger      (pieo_enq_trigger),
    .head_len_rd_en        (head_len_rd_en),
    .head_len_rd_addr      (head_len_rd_addr),
    .head_len_rd_data      (head_len_rd_data),
    .weight_shift          (weight_shift),
    .now                   (now),
    .pieo_enq_valid        (pieo_enq_valid),
    .pieo_enq_ready        (pieo_enq_ready),
    .pieo_enq_fifo         (pieo_enq_fifo),
    .pieo_enq_rank         (pieo_enq_rank),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] fifo;
    logic [LW-1:0] len;
    logic [HW-1:0] shift;
    logic [RW-1:0] now;
    int            hold;
    logic          keep;
    logic [RW-1:0] exp_rank;
  } vec_t;

  typedef struct {
    logic [SW-1:0] fifo;
    logic [RW-1:0] rank;
  } exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        exp_q[$];
  logic [LW-1:0] head_len_mem [NF];
  vec_t        vecs [12];
  vec_t        post [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Head-length memory: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk)
    head_len_rd_data <= head_len_rd_en ? head_len_mem[head_len_rd_addr] : 16'hBAD0;

  // Scoreboard pop on accept, plus stability of a stalled request.
  logic          prev_vld = 1'b0, prev_rdy = 1'b0;
  logic [SW-1:0] prev_fifo;
  logic [RW-1:0] prev_rank;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (prev_vld && !prev_rdy) begin
        chk("stall_valid", pieo_enq_valid, 1);
        chk("stall_fifo", pieo_enq_fifo, prev_fifo);
        chk("stall_rank", pieo_enq_rank, prev_rank);
      end
      if (pieo_enq_valid && pieo_enq_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_enq", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("enq_fifo", pieo_enq_fifo, e.fifo);
          chk("enq_rank", pieo_enq_rank, e.rank);
        end
      end
      prev_vld  = pieo_enq_valid;
      prev_rdy  = pieo_enq_ready;
      prev_fifo = pieo_enq_fifo;
      prev_rank = pieo_enq_rank;
    end
  end

  // Entered at posedge+1 with the DUT idle; leaves at posedge+1 after the accepting edge.
  task automatic run_vec(input vec_t v);
    exp_t e;
    head_len_mem[v.fifo] = v.len;
    weight_shift[int'(v.fifo)*HW +: HW] = v.shift;
    now = v.now;
    fifo_to_enqueue       = v.fifo;
    fifo_to_enqueue_valid = 1'b1;
    pieo_enq_ready        = (v.hold == 0);
    e.fifo = v.fifo;
    e.rank = v.exp_rank;
    exp_q.push_back(e);
    @(negedge clk);
    chk("claim_trigger", pieo_enq_trigger, 1);
    chk("claim_rd_en", head_len_rd_en, 1);
    chk("claim_rd_addr", head_len_rd_addr, v.fifo);
    chk("claim_busy", busy, 0);
    @(posedge clk); #1;
    fifo_to_enqueue_valid = v.keep;
    @(negedge clk);
    chk("fetch_busy", busy, 1);
    chk("fetch_trigger", pieo_enq_trigger, 0);
    chk("fetch_valid", pieo_enq_valid, 0);
    @(posedge clk); #1;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("hold_trigger", pieo_enq_trigger, 0);
      chk("hold_busy", busy, 1);
      @(posedge clk); #1;
    end
    pieo_enq_ready = 1'b1;
    @(negedge clk);
    chk("req_valid", pieo_enq_valid, 1);
    chk("req_trigger", pieo_enq_trigger, 0);
    @(posedge clk); #1;
    fifo_to_enqueue_valid = v.keep;
  endtask

  initial begin
    // fifo, len, shift, now, hold, keep, expected rank
    vecs[0]  = '{2'd2, 16'd1500,  3'd0, 32'd100,        0, 1'b0, 32'd100};
    vecs[1]  = '{2'd2, 16'd500,   3'd0, 32'd200,        0, 1'b0, 32'd1600};
    vecs[2]  = '{2'd1, 16'd1024,  3'd3, 32'd50,         0, 1'b0, 32'd50};
    vecs[3]  = '{2'd2, 16'd10,    3'd0, 32'd0,          5, 1'b1, 32'd2100};
    vecs[4]  = '{2'd2, 16'd20,    3'd0, 32'd0,          0, 1'b0, 32'd2110};
    vecs[5]  = '{2'd1, 16'd8,     3'd1, 32'd300,        0, 1'b0, 32'd300};
    vecs[6]  = '{2'd1, 16'd0,     3'd0, 32'd100,        0, 1'b0, 32'd304};
    vecs[7]  = '{2'd0, 16'h0100,  3'd0, 32'hFFFF_FE00,  0, 1'b0, 32'hFFFF_FE00};
    vecs[8]  = '{2'd0, 16'h0200,  3'd0, 32'd0,          0, 1'b0, 32'hFFFF_FF00};
    vecs[9]  = '{2'd0, 16'd1,     3'd0, 32'd5,          0, 1'b0, 32'hFFFF_FFFF};
    vecs[10] = '{2'd3, 16'hFFFF,  3'd7, 32'd7,          0, 1'b0, 32'd7};
    vecs[11] = '{2'd3, 16'd4,     3'd0, 32'd0,          0, 1'b0, 32'h206};
    for (int i = 0; i < NF; i++)
      post[i] = '{SW'(i), 16'd0, 3'd0, 32'd0, 0, 1'b0, 32'd0};

    rst_n = 1'b0;
    fifo_to_enqueue_valid = 1'b0;
    fifo_to_enqueue = '0;
    pieo_enq_ready = 1'b0;
    weight_shift = '0;
    now = '0;
    for (int i = 0; i < NF; i++) head_len_mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", pieo_enq_valid, 0);
    chk("rst_trigger", pieo_enq_trigger, 0);
    chk("rst_rd_en", head_len_rd_en, 0);
    chk("rst_rd_addr", head_len_rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo", pieo_enq_fifo, 0);
    chk("rst_rank", pieo_enq_rank, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Reset while a request is stalled in REQ: dropped at once, no accept.
    head_len_mem[2] = 16'd77;
    now = 32'd9;
    fifo_to_enqueue = 2'd2;
    fifo_to_enqueue_valid = 1'b1;
    pieo_enq_ready = 1'b0;
    @(negedge clk);
    chk("rr_trigger", pieo_enq_trigger, 1);
    @(posedge clk); #1;
    fifo_to_enqueue_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_req_valid", pieo_enq_valid, 1);
    chk("rr_req_rank", pieo_enq_rank, 32'd2130);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_valid", pieo_enq_valid, 0);
    chk("rr_busy", busy, 0);
    chk("rr_fifo", pieo_enq_fifo, 0);
    chk("rr_rank", pieo_enq_rank, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pieo_enq_ready = 1'b1;
    @(negedge clk);
    chk("rr_idle_busy", busy, 0);
    @(posedge clk); #1;

    // Every finish time must be back at zero.
    for (int i = 0; i < NF; i++) run_vec(post[i]);

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d expected enqueues outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pieo_enq_ctrl.md
# pieo_enq_ctrl

Enqueue controller that sits directly downstream of the FIFO enqueue tracker and upstream of the PIEO ordered list. Each cycle the tracker offers an eligible FIFO index. The block claims it with a one-cycle `pieo_enq_trigger` pulse. It then reads that FIFO's head-packet length and computes a start-time-fair-queueing rank from a per-FIFO virtual finish time. Finally it delivers `{fifo, rank}` to the PIEO over a valid/ready handshake.

## Interface
Parameters:
- `NUM_FIFO`, 4: number of FIFOs.
- `SEL_WIDTH`, `$clog2(NUM_FIFO)`: FIFO index width.
- `LEN_WIDTH`, 16: packet length width in bytes.
- `RANK_WIDTH`, 32: rank and virtual-time width.
- `SHIFT_WIDTH`, 3: per-FIFO weight shift width.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fifo_to_enqueue_valid`  in  1  tracker offers a FIFO.
- `fifo_to_enqueue`  in  `SEL_WIDTH`  offered FIFO index.
- `pieo_enq_trigger`  out  1  one-cycle claim pulse to the tracker.
- `head_len_rd_en`  out  1  head-length read strobe.
- `head_len_rd_addr`  out  `SEL_WIDTH`  FIFO index to read.
- `head_len_rd_data`  in  `LEN_WIDTH`  head length; valid exactly 1 cycle after `rd_en`.
- `weight_shift`  in  `NUM_FIFO*SHIFT_WIDTH`  per-FIFO shift; FIFO i occupies bits `[i*SHIFT_WIDTH +: SHIFT_WIDTH]`.
- `now`  in  `RANK_WIDTH`  free-running system virtual time.
- `pieo_enq_valid`  out  1  enqueue request.
- `pieo_enq_ready`  in  1  PIEO accepts.
- `pieo_enq_fifo`  out  `SEL_WIDTH`  element FIFO id.
- `pieo_enq_rank`  out  `RANK_WIDTH`  element rank.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states are IDLE, FETCH and REQ.
- **IDLE**, when `fifo_to_enqueue_valid`=1:
  - Same cycle, combinationally: `pieo_enq_trigger`=1, `head_len_rd_en`=1, `head_len_rd_addr`=`fifo_to_enqueue`.
  - Register `sel`=`fifo_to_enqueue`, then go to FETCH.
  - The trigger always coincides with the index being claimed; it never fires outside IDLE.
- **FETCH**, one cycle:
  - `q` = `head_len_rd_data >> weight_shift[sel]`, zero-extended to `RANK_WIDTH`.
  - `start` = max(`now`, `last_finish[sel]`), unsigned compare.
  - `finish` = `start + q`, computed `RANK_WIDTH+1` wide and saturated to all-ones on carry.
  - Register `pieo_enq_rank`=`start`, `pieo_enq_fifo`=`sel`, `last_finish[sel]`=`finish`, `pieo_enq_valid`=1, then go to REQ.
- **REQ**:
  - Hold `pieo_enq_valid`, `pieo_enq_fifo` and `pieo_enq_rank` stable until `pieo_enq_ready`=1.
  - On the accepting edge, clear valid and return to IDLE.
  - Withdrawal is forbidden; the request is committed once issued.
- A new offer is not examined until IDLE is re-entered. Triggers are therefore at least 3 cycles apart, which covers the tracker's 2-cycle mask-to-valid update. The block never re-claims a FIFO it has just triggered.
- `last_finish` is a `NUM_FIFO`×`RANK_WIDTH` register array. Only the selected entry changes; the others hold.
- Saturated `last_finish` stays at all-ones until reset.

## Timing
- Reset values:
  - state = IDLE.
  - `pieo_enq_valid`, `pieo_enq_trigger`, `head_len_rd_en`, `busy` = 0.
  - `pieo_enq_fifo` = 0, `pieo_enq_rank` = 0, `head_len_rd_addr` = 0.
  - all `last_finish` = 0.
- Latency: offer seen at cycle t gives trigger at t, `pieo_enq_valid` high from t+2. With ready already high, the accept is at t+2 and the next trigger is possible at t+3.
- `busy` is 1 in FETCH and REQ.
- Reset asserted mid-operation:
  - The FSM returns to IDLE immediately and the request is dropped.
  - The tracker's claimed bit is not restored by this block. A system-level reset clears both sides.
- `weight_shift` and `now` are sampled only in FETCH.
- An offer that disappears before IDLE is re-entered is ignored.

## Structure
- Package `pieo_sched_pkg` holds:
  - the state enum (IDLE/FETCH/REQ);
  - default widths `LEN_WIDTH`, `RANK_WIDTH`, `SHIFT_WIDTH`;
  - `RANK_MAX` (all-ones) for saturation.
- Sub-module `vft_calc` is combinational: shift, max, saturating add. It is instantiated once and driven by `sel`.
- The FSM, the `last_finish` array and the output registers live in the top.

## Test plan
- Reset, then offer FIFO 2, `len`=1500, shift=0, `now`=100, ready=1 -> trigger at t; accept at t+2 with `{fifo 2, rank 100}`; `last_finish[2]`=1600.
- Offer FIFO 2 again, `len`=500, `now`=200 -> rank 1600; `last_finish[2]`=2100.
- Offer FIFO 1, `len`=1024, shift=3, `now`=50 -> rank 50; `last_finish[1]`=178; FIFO 2's entry is unchanged.
- Hold ready=0 for 5 cycles in REQ while the offer stays valid -> no second trigger, outputs stable; accept on cycle 6; next trigger no earlier than the cycle after the accept.
- `last_finish[0]`=0xFFFF_FF00, `len`=0x200 -> rank 0xFFFF_FF00; `last_finish[0]` saturates to 0xFFFF_FFFF.
- Assert `rst_n`=0 during REQ -> `pieo_enq_valid`=0 immediately, FSM in IDLE, all `last_finish` = 0.
